aes_128_arbiter: RTL
====================

// Module: aes_128_arbiter
// PURPOSE
//  Shares one fully pipelined aes_128 core (one block/cycle, fixed latency, no stall) among NUM_REQ requesters.
//  Round-robin grants valid/ready requests, drives core state/key, tracks in-flight owner IDs in a tag delay line,
//  buffers results in a credit-protected response FIFO so backpressure on rsp never drops a core output.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  LATENCY  20  core cycles from state/key presented to out valid (must equal aes_128 pipeline depth)
//  DEPTH    24  response FIFO entries; DEPTH >= LATENCY+2 sustains 1 block/cycle
// PORTS
//  clk         in   1            clock, all state on posedge
//  rst_n       in   1            async active-low reset
//  req_valid   in   NUM_REQ      per-requester block valid
//  req_ready   out  NUM_REQ      per-requester accept (one-hot or zero)
//  req_state   in   NUM_REQ*128  plaintext, requester i at [i*128 +: 128]
//  req_key     in   NUM_REQ*128  key, same packing
//  core_state  out  128          to aes_128.state
//  core_key    out  128          to aes_128.key
//  core_out    in   128          from aes_128.out
//  rsp_valid   out  1            response FIFO head valid
//  rsp_ready   in   1            consumer accept
//  rsp_data    out  128          ciphertext
//  rsp_id      out  ID_W         owning requester, ID_W = max(1,$clog2(NUM_REQ))
//  busy        out  1            any tag in flight or FIFO non-empty
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, busy=0, rr_ptr=0, credits=DEPTH, tag line cleared, FIFO empty.
//  Issue: issue = |req_valid && credits!=0. Grant = first valid at/after rr_ptr (wrap). Combinational;
//   req_ready may depend on req_valid. Transfer on req_valid[i]&&req_ready[i].
//  On issue: rr_ptr <= grant_idx+1 (wraps NUM_REQ-1 -> 0); else unchanged.
//  core_state/core_key = granted request's data; 0 when no issue.
//  Tag line: LATENCY stages of {v,id}; stage0 <= {issue,grant_idx}; shift each cycle. When stage[LATENCY-1].v,
//   push {core_out,id} into FIFO that cycle. Issue->rsp_valid min LATENCY+1 cycles.
//  Credits: -1 on issue, +1 on pop (rsp_valid&&rsp_ready), both same cycle -> unchanged. Range 0..DEPTH.
//   credits==0 -> req_ready all 0. Guarantees push never meets full FIFO; full-push is assertion failure.
//  Response: rsp_valid/rsp_data/rsp_id registered FIFO head, stable while rsp_valid&&!rsp_ready.
//   Order is strict issue order; no reordering per requester.
//  Push and pop same cycle on a non-empty FIFO allowed; push on empty FIFO shows rsp_valid next cycle.
//  Reset mid-operation: tags, FIFO, credits cleared; core is unreset, its stale outputs are ignored (tags invalid).
//  busy = |tag.v || fifo_count!=0.
// CONFIGURATION
//  AES_ARB_PERF_EN defined: adds outputs perf_issued[31:0] (+1 per issue) and perf_stall[31:0]
//   (+1 per cycle with |req_valid && credits==0); both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package aes_arb_pkg: AES_BLK_W=128, AES_CORE_LATENCY=20, typedef aes_rsp_t {logic[127:0] data; id}.
//  One sub-module: aes_rsp_fifo (sync FIFO, DEPTH x aes_rsp_t, registered head, count out).
//  Round-robin, tag line, credit counter inline in top.
// TESTING
//  FIPS-197: req0 key 000102..0f, state 00112233..eeff, rsp_ready=1 -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, id 0,
//   rsp_valid exactly LATENCY+1 cycles after issue.
//  All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, ids out in same order.
//  rsp_ready=0, req0 always valid -> exactly DEPTH issues, then req_ready=0; raise rsp_ready -> no loss, issues resume.
//  Pop and issue same cycle at credits==1 -> credits stays 1, no extra stall.
//  rst_n low with 10 blocks in flight -> rsp_valid 0, busy 0, none of the 10 ever appear after reset release.
//  AES_ARB_PERF_EN: 8 issues plus 5 credit-stall cycles -> perf_issued=8, perf_stall=5.

Source files
------------

// File: rtl/aes_128_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// aes_arb_pkg
// Shared definitions for the AES-128 core arbiter slice.
//   AES_BLK_W        : width of one AES block / key (128)
//   AES_CORE_LATENCY : pipeline depth of the shared aes_128 core
//   AES_ID_MAX_W     : storage width for requester IDs inside the response FIFO
//   aes_rsp_t        : one response FIFO entry {ciphertext, owning requester}
//   aes_id_w()       : requester-ID width for a given requester count
// ---------------------------------------------------------------------------
package aes_arb_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_CORE_LATENCY = 20;
    localparam int AES_ID_MAX_W     = 8;

    typedef struct packed {
        logic [AES_BLK_W-1:0]    data;
        logic [AES_ID_MAX_W-1:0] id;
    } aes_rsp_t;

    // Width of a requester index; never below one bit.
    function automatic int aes_id_w(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/aes_128_arbiter_if.sv
// ---------------------------------------------------------------------------
// aes_128_arbiter_if
// Requester and response bus of the AES-128 arbiter.
//   req_valid/req_ready : per-requester valid/ready handshake
//   req_state/req_key   : packed plaintext/key, requester i at [i*128 +: 128]
//   rsp_valid/rsp_ready : response handshake toward the single consumer
//   rsp_data/rsp_id     : ciphertext and the requester that owns it
// Modports:
//   master : requesters + consumer side (drives requests, accepts responses)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface aes_128_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = aes_arb_pkg::aes_id_w(NUM_REQ)
);

    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0]                        req_ready;
    logic [NUM_REQ*aes_arb_pkg::AES_BLK_W-1:0] req_state;
    logic [NUM_REQ*aes_arb_pkg::AES_BLK_W-1:0] req_key;
    logic                                      rsp_valid;
    logic                                      rsp_ready;
    logic [aes_arb_pkg::AES_BLK_W-1:0]         rsp_data;
    logic [ID_W-1:0]                           rsp_id;

    modport master (
        output req_valid, req_state, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_state, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/aes_128_arbiter_rsp_fifo.sv
// ---------------------------------------------------------------------------
// aes_rsp_fifo
// Synchronous FIFO of aes_rsp_t entries used to hold core results until the
// consumer takes them. The head entry and its valid flag come straight from
// flops, so they stay stable while the consumer stalls.
// Ports:
//   clk, rst_n  : clock, async active-low reset (pointers and count only)
//   push        : write push_data this cycle
//   push_data   : entry to write
//   pop         : consume the head entry (ignored when empty)
//   head        : oldest entry
//   head_valid  : FIFO non-empty
//   count       : number of stored entries
// ---------------------------------------------------------------------------
module aes_rsp_fifo
    import aes_arb_pkg::*;
#(
    parameter  int DEPTH = 24,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  aes_rsp_t         push_data,
    input  logic             pop,
    output aes_rsp_t         head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    aes_rsp_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_en;

    assign pop_en     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The arbiter's credit scheme must never let a push land on a full FIFO.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && (count == CNT_W'(DEPTH)))
    );

endmodule

// File: rtl/aes_128_arbiter.sv
// ---------------------------------------------------------------------------
// aes_128_arbiter
// Shares one fully pipelined aes_128 core (one block per cycle, fixed latency,
// no stall) among NUM_REQ requesters. A round-robin picker grants one valid
// request per cycle, the granted state/key go straight to the core, a tag
// delay line remembers who owns each in-flight block, and finished blocks are
// parked in a response FIFO. A credit counter reserves a FIFO slot for every
// issued block, so consumer backpressure can never drop a core output.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : requester handshake/data and response handshake/data
//   core_state   : plaintext to aes_128.state (0 when nothing issues)
//   core_key     : key to aes_128.key (0 when nothing issues)
//   core_out     : ciphertext from aes_128.out, LATENCY cycles later
//   busy         : any block in flight or waiting in the response FIFO
//   perf_issued  : (AES_ARB_PERF_EN only) blocks issued, wraps at 2^32
//   perf_stall   : (AES_ARB_PERF_EN only) cycles with a request held off by
//                  zero credits, wraps at 2^32
//
// Configuration macro: AES_ARB_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module aes_128_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = AES_CORE_LATENCY,
    parameter int DEPTH   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_128_arbiter_if.slave     bus,
    output logic [AES_BLK_W-1:0] core_state,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic [AES_BLK_W-1:0] core_out,
`ifdef AES_ARB_PERF_EN
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall,
`endif
    output logic                 busy
);

    localparam int ID_W  = aes_id_w(NUM_REQ);
    localparam int CRD_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W:0]    cand;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             issue;

    logic [CRD_W-1:0] credits;

    logic [LATENCY-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [LATENCY];

    logic             push_en;
    aes_rsp_t         push_data;
    logic             pop_en;
    aes_rsp_t         fifo_head;
    logic             fifo_valid;
    logic [CRD_W-1:0] fifo_count;
    logic             unused_id_bits;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // A grant only turns into an issue while a FIFO slot is reserved for it.
    always_comb begin
        issue         = grant_found && (credits != '0);
        bus.req_ready = '0;
        core_state    = '0;
        core_key      = '0;
        if (issue) begin
            bus.req_ready[grant_idx] = 1'b1;
            core_state = AES_BLK_W'(bus.req_state >> (AES_BLK_W * int'(grant_idx)));
            core_key   = AES_BLK_W'(bus.req_key >> (AES_BLK_W * int'(grant_idx)));
        end
    end

    // Next search starts just past the requester served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Tag line mirrors the core pipeline; the last stage lines up with core_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LATENCY-2:0], issue};
            tag_id[0] <= grant_idx;
            for (int i = 1; i < LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Capture the core result together with the owner tag that travelled with it.
    always_comb begin
        push_en        = tag_v[LATENCY-1];
        push_data.data = core_out;
        push_data.id   = AES_ID_MAX_W'(tag_id[LATENCY-1]);
    end

    assign pop_en = fifo_valid && bus.rsp_ready;

    aes_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_en),
        .push_data  (push_data),
        .pop        (pop_en),
        .head       (fifo_head),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    // Credits count free FIFO slots not yet promised to an in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRD_W'(DEPTH);
        end else begin
            case ({issue, pop_en})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    a_credit_range: assert property (
        @(posedge clk) disable iff (!rst_n) credits <= CRD_W'(DEPTH)
    );

    assign bus.rsp_valid  = fifo_valid;
    assign bus.rsp_data   = fifo_head.data;
    assign bus.rsp_id     = fifo_head.id[ID_W-1:0];
    assign unused_id_bits = ^(fifo_head.id >> ID_W);

    assign busy = (|tag_v) || (fifo_count != '0);

`ifdef AES_ARB_PERF_EN
    // Issue and credit-starvation counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if ((|bus.req_valid) && (credits == '0)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
